// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM state type and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULU = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_DIVU = 2'd3;

  localparam int          ITER_COUNT    = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle between the issue logic (master) and the multiply/divide unit (slave).
interface muldiv_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [ADDR_W-1:0] dest;
  logic              flush;
  logic              busy;
  logic              done;
  logic              enc;
  logic [ADDR_W-1:0] addrc;
  logic [WIDTH-1:0]  datac;
  logic [WIDTH-1:0]  hi;

  modport master (
    output start, op, opa, opb, dest, flush,
    input  busy, done, enc, addrc, datac, hi
  );

  modport slave (
    input  start, op, opa, opb, dest, flush,
    output busy, done, enc, addrc, datac, hi
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of a word pair: two independent words,
// or one double-width word when wide is set (sign taken from neg_hi).
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_hi,
  input  logic [WIDTH-1:0] val_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             wide,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] full_neg;

  assign full_neg = -{val_hi, val_lo};

  always_comb begin
    if (wide) begin
      {res_hi, res_lo} = neg_hi ? full_neg : {val_hi, val_lo};
    end else begin
      res_hi = neg_hi ? -val_hi : val_hi;
      res_lo = neg_lo ? -val_lo : val_lo;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit writing back through the register-file port.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic     clock,
  input logic     reset,
  muldiv_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start
  // BUSY  | one shift-add / restoring-subtract step per cycle
  // FIXUP | phase 0 sign-corrects acc, phase 1 stages the writeback
  // DONE  | done/enc pulse with results valid; start here issues back-to-back

  state_e             state, state_nx;
  logic               fix_ph;
  logic               is_div_q, neg_res, neg_rem;
  logic [ADDR_W-1:0]  dest_q;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mult;
  logic               busy_q, done_q, enc_q;
  logic [ADDR_W-1:0]  addrc_q;
  logic [WIDTH-1:0]   datac_q, hi_q;

  logic               is_div_in, signed_in, div0_in, skip_busy, last_iter;
  logic               load_ops, load_out;
  logic [WIDTH-1:0]   mag_a, mag_b, fix_hi, fix_lo, rem_nx, quo_nx;
  logic [WIDTH:0]     div_shift, div_diff;

  assign is_div_in = op_is_div(bus.op);
  assign signed_in = op_is_signed(bus.op);
  assign div0_in   = is_div_in && (bus.opb == '0);

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_busy = div0_in || (!is_div_in && (bus.opb == '0));
  assign last_iter = (cnt == 6'(ITER_COUNT - 1)) || (!is_div_q && (mult[WIDTH-1:1] == '0));
`else
  assign skip_busy = div0_in;
  assign last_iter = (cnt == 6'(ITER_COUNT - 1));
`endif

  muldiv_signfix #(.WIDTH(WIDTH)) u_entry (
    .val_hi (bus.opa),
    .val_lo (bus.opb),
    .neg_hi (signed_in && bus.opa[WIDTH-1]),
    .neg_lo (signed_in && bus.opb[WIDTH-1]),
    .wide   (1'b0),
    .res_hi (mag_a),
    .res_lo (mag_b)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fixup (
    .val_hi (acc[2*WIDTH-1:WIDTH]),
    .val_lo (acc[WIDTH-1:0]),
    .neg_hi (is_div_q ? neg_rem : neg_res),
    .neg_lo (neg_res),
    .wide   (!is_div_q),
    .res_hi (fix_hi),
    .res_lo (fix_lo)
  );

  // Restoring step: acc holds {remainder, dividend-shifting-into-quotient}
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand[WIDTH-1:0]};
  assign rem_nx    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign quo_nx    = {acc[WIDTH-2:0], ~div_diff[WIDTH]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      fix_ph <= 1'b0;
    end else begin
      state  <= state_nx;
      fix_ph <= (state == FIXUP) && !fix_ph && !bus.flush;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = skip_busy ? FIXUP : BUSY;
      BUSY:    if (last_iter) state_nx = FIXUP;
      FIXUP:   if (fix_ph) state_nx = DONE;
      DONE:    state_nx = bus.start ? (skip_busy ? FIXUP : BUSY) : IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_comb begin
    load_ops = bus.start && !bus.flush && ((state == IDLE) || (state == DONE));
    load_out = (state_nx == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dest_q   <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mult     <= '0;
    end else if (load_ops) begin
      is_div_q <= is_div_in;
      neg_res  <= signed_in && !div0_in && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
      neg_rem  <= signed_in && is_div_in && !div0_in && bus.opa[WIDTH-1];
      dest_q   <= bus.dest;
      cnt      <= '0;
      mult     <= mag_b;
      mcand    <= {{WIDTH{1'b0}}, is_div_in ? mag_b : mag_a};
      if (div0_in)        acc <= {bus.opa, WIDTH'(DIV0_QUOTIENT)};
      else if (is_div_in) acc <= {{WIDTH{1'b0}}, mag_a};
      else                acc <= '0;
    end else if (!bus.flush) begin
      if (state == BUSY) begin
        cnt <= cnt + 6'd1;
        if (is_div_q) begin
          acc <= {rem_nx, quo_nx};
        end else begin
          if (mult[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
        end
      end else if ((state == FIXUP) && !fix_ph) begin
        acc <= {fix_hi, fix_lo};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      enc_q   <= 1'b0;
      addrc_q <= '0;
      datac_q <= '0;
      hi_q    <= '0;
    end else begin
      busy_q <= (state_nx == BUSY) || (state_nx == FIXUP);
      done_q <= load_out;
      enc_q  <= load_out && (dest_q != '0);
      if (load_out) begin
        hi_q <= acc[2*WIDTH-1:WIDTH];
        if (dest_q != '0) begin
          addrc_q <= dest_q;
          datac_q <= acc[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.enc   = enc_q;
  assign bus.addrc = addrc_q;
  assign bus.datac = datac_q;
  assign bus.hi    = hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit; honours MULDIV_EARLY_OUT_EN for expected latencies.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc = 0;
  int unsigned t_issue = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  typedef struct {
    string       tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  addr;
    logic        en;
    int          lat;
  } exp_t;

  exp_t sb[$];

  muldiv_if #(.WIDTH(32), .ADDR_W(5)) bus ();

  muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_v;
    logic [63:0] ua, ub, q, r;
    sa   = {{32{a[31]}}, a};
    sb_v = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    if (op[1] && (b == 32'd0)) return {a, 32'hFFFF_FFFF};
    case (op)
      OP_MUL:  return sa * sb_v;
      OP_MULU: return ua * ub;
      OP_DIV:  begin q = sa / sb_v; r = sa % sb_v; end
      default: begin q = ua / ub; r = ua % ub; end
    endcase
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1]) return (b == 32'd0) ? 2 : 34;
`ifdef MULDIV_EARLY_OUT_EN
    begin
      logic [31:0] mb;
      int top;
      mb = (op == OP_MUL && b[31]) ? -b : b;
      if (mb == 32'd0) return 2;
      top = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) top = i;
      return 3 + top;
    end
`else
    return 34;
`endif
  endfunction

  // Call at a negedge: start is sampled on the following rising edge.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input bit expect_done);
    logic [63:0] r;
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    bus.dest  = d;
    if (expect_done) begin
      r      = model_res(op, a, b);
      e.tag  = tag;
      e.lo   = r[31:0];
      e.hi   = r[63:32];
      e.addr = d;
      e.en   = (d != 5'd0);
      e.lat  = model_lat(op, b);
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    t_issue   = cyc;
  endtask

  task automatic wait_done();
    int   n_busy;
    bit   seen;
    exp_t e;
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (bus.busy) n_busy++;
      if (bus.done) seen = 1'b1;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s timeout: done not seen within 100 cycles", e.tag);
      return;
    end
    check({e.tag, " latency"}, 64'(cyc - t_issue), 64'(e.lat));
    check({e.tag, " busy_cycles"}, 64'(n_busy), 64'(e.lat));
    check({e.tag, " enc"}, 64'(bus.enc), 64'(e.en));
    check({e.tag, " hi"}, 64'(bus.hi), 64'(e.hi));
    last_hi = e.hi;
    if (e.en) begin
      check({e.tag, " addrc"}, 64'(bus.addrc), 64'(e.addr));
      check({e.tag, " datac"}, 64'(bus.datac), 64'(e.lo));
      last_lo = e.lo;
    end
  endtask

  initial begin
    int pulses;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = OP_MUL;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.dest  = '0;

    #12;
    check("reset busy",  64'(bus.busy),  64'(0));
    check("reset done",  64'(bus.done),  64'(0));
    check("reset enc",   64'(bus.enc),   64'(0));
    check("reset addrc", 64'(bus.addrc), 64'(0));
    check("reset datac", 64'(bus.datac), 64'(0));
    check("reset hi",    64'(bus.hi),    64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    issue("mulu_max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
    wait_done();
    @(negedge clock);
    issue("mul_neg", OP_MUL, 32'hFFFF_FFF9, 32'd6, 5'd5, 1'b1);
    wait_done();
    @(negedge clock);
    issue("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
    wait_done();
    @(negedge clock);
    issue("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd12, 1'b1);
    wait_done();
    @(negedge clock);
    issue("divu_by0", OP_DIVU, 32'd100, 32'd0, 5'd7, 1'b1);
    wait_done();
    @(negedge clock);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    wait_done();
    issue("b2b_divu", OP_DIVU, 32'd1000, 32'd7, 5'd9, 1'b1);
    wait_done();

    @(negedge clock);
    issue("flush", OP_MULU, 32'h1234_5678, 32'h8000_0009, 5'd10, 1'b0);
    repeat (9) @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    @(negedge clock);
    check("flush busy", 64'(bus.busy), 64'(0));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done || bus.enc) pulses++;
    end
    check("flush no_pulse", 64'(pulses), 64'(0));
    check("flush hi_hold", 64'(bus.hi), 64'(last_hi));
    check("flush datac_hold", 64'(bus.datac), 64'(last_lo));

    issue("mulu_small", OP_MULU, 32'd5, 32'd3, 5'd11, 1'b1);
    wait_done();
    @(negedge clock);
    check("done one_cycle", 64'(bus.done), 64'(0));
    check("enc one_cycle", 64'(bus.enc), 64'(0));

    issue("dest0", OP_MULU, 32'h0001_0000, 32'h0003_0000, 5'd0, 1'b1);
    wait_done();
    @(negedge clock);

    issue("rst_mid", OP_MUL, 32'hFFFF_FFFB, 32'd1234567, 5'd14, 1'b0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async busy",  64'(bus.busy),  64'(0));
    check("async done",  64'(bus.done),  64'(0));
    check("async enc",   64'(bus.enc),   64'(0));
    check("async addrc", 64'(bus.addrc), 64'(0));
    check("async datac", 64'(bus.datac), 64'(0));
    check("async hi",    64'(bus.hi),    64'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset busy", 64'(bus.busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
